// File: rtl/mult16_unit.sv
// Iterative shift-add multiplier: one partial-product step per clock, WIDTH steps per product.
// Signed operands are reduced to magnitudes up front and the sign is reapplied to the final product.
module mult16_unit #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 2 * WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] result,
  output logic [1:0]           state_dbg
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: start is sampled only while idle; busy is high for the WIDTH
  // steps of an operation; done pulses for one cycle and result is valid from
  // that cycle until the next accepted start or reset.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 neg_q, neg_d;
  logic                 sm_q, sm_d;
  logic [OUT_WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       acc_nxt;
  logic [WIDTH-1:0]     mplier_nxt;
  logic [OUT_WIDTH-1:0] product;

  // Magnitude of the most negative value wraps to itself, which is exactly
  // the correct unsigned magnitude, so no extra bit is needed.
  always_comb begin
    mag_a = op_a;
    mag_b = op_b;
    if (signed_mode && op_a[WIDTH-1]) mag_a = (~op_a) + WIDTH'(1);
    if (signed_mode && op_b[WIDTH-1]) mag_b = (~op_b) + WIDTH'(1);
  end

  always_comb begin
    sum = acc_q;
    if (mplier_q[0]) sum = acc_q + {1'b0, mcand_q};
    acc_nxt    = {1'b0, sum[WIDTH:1]};
    mplier_nxt = {sum[0], mplier_q[WIDTH-1:1]};
    product    = {sum, mplier_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    sm_d     = sm_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = mag_a;
          mplier_d = mag_b;
          acc_d    = '0;
          count_d  = '0;
          sm_d     = signed_mode;
          neg_d    = signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_nxt;
        mplier_d = mplier_nxt;
        count_d  = count_q + CW'(1);
        // The last step writes the whole product at once so result never shows partial sums.
        if (count_q == CW'(WIDTH - 1)) begin
          state_d  = S_DONE;
          result_d = (sm_q && neg_q) ? (~product) + OUT_WIDTH'(1) : product;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      sm_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      sm_q     <= sm_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule
